// File: rtl/pwrmgr_cdc_sync_ctrl.sv
// Fast-domain sequencer for the power manager configuration CDC path: batches sync
// requests, launches one sync pulse per batch, and acks each batch on done or timeout.
module pwrmgr_cdc_sync_ctrl #(
   parameter int NumReq        = 3,
   parameter int TimeoutCycles = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NumReq-1:0] req_i,
   output logic [NumReq-1:0] ack_o,
   output logic              ack_err_o,
   output logic              busy_o,
   output logic              cfg_cdc_sync_o,
   input  logic              cdc_sync_done_i,
   output logic              timeout_o,
   output logic              spurious_o,
   input  logic              clr_err_i
);

   localparam int CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_e;

   state_e            state_q, state_d;
   logic [NumReq-1:0] pending_q, pending_d, pending_n;
   logic [NumReq-1:0] batch_q, batch_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [NumReq-1:0] ack_q, ack_d;
   logic              ack_err_q, ack_err_d;
   logic              sync_q, sync_d;
   logic              timeout_q, timeout_d;
   logic              spurious_q, spurious_d;
   logic              launch;
   logic              timeout_set, spurious_set;

   assign pending_d = pending_q | req_i;

   always_comb begin
      state_d      = state_q;
      pending_n    = pending_d;
      batch_d      = batch_q;
      cnt_d        = cnt_q;
      ack_d        = '0;
      ack_err_d    = 1'b0;
      sync_d       = 1'b0;
      launch       = 1'b0;
      timeout_set  = 1'b0;
      spurious_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            spurious_set = cdc_sync_done_i;
            launch       = (pending_d != '0);
         end
         ST_WAIT: begin
            if (cnt_q != CntLast) cnt_d = cnt_q + CntW'(1);
            // Done takes priority over the timeout threshold in the same cycle.
            if (cdc_sync_done_i) begin
               ack_d   = batch_q;
               batch_d = '0;
               state_d = ST_IDLE;
               launch  = (pending_d != '0);
            end else if (cnt_q == CntLast) begin
               ack_d       = batch_q;
               ack_err_d   = 1'b1;
               timeout_set = 1'b1;
               batch_d     = '0;
               state_d     = ST_IDLE;
               launch      = (pending_d != '0);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Requests collected up to and including the completion cycle form the next
      // batch, so its launch coincides with the ack of the previous one.
      if (launch) begin
         batch_d   = pending_d;
         pending_n = '0;
         sync_d    = 1'b1;
         cnt_d     = '0;
         state_d   = ST_WAIT;
      end
      timeout_d  = timeout_set  | (timeout_q  & ~clr_err_i);
      spurious_d = spurious_set | (spurious_q & ~clr_err_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         batch_q    <= '0;
         cnt_q      <= '0;
         ack_q      <= '0;
         ack_err_q  <= 1'b0;
         sync_q     <= 1'b0;
         timeout_q  <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_n;
         batch_q    <= batch_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         ack_err_q  <= ack_err_d;
         sync_q     <= sync_d;
         timeout_q  <= timeout_d;
         spurious_q <= spurious_d;
      end
   end

   assign ack_o          = ack_q;
   assign ack_err_o      = ack_err_q;
   assign busy_o         = (state_q == ST_WAIT);
   assign cfg_cdc_sync_o = sync_q;
   assign timeout_o      = timeout_q;
   assign spurious_o     = spurious_q;

endmodule

// File: tb/tb_pwrmgr_cdc_sync_ctrl.sv
// Bench for pwrmgr_cdc_sync_ctrl: expected launch cycles and acks are queued by the
// driver tasks and compared by a negedge monitor as the DUT produces them.
module tb_pwrmgr_cdc_sync_ctrl;

   localparam int NumReq = 3;
   localparam int TimeoutCycles = 8;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [NumReq-1:0] req_i = '0;
   logic [NumReq-1:0] ack_o;
   logic              ack_err_o;
   logic              busy_o;
   logic              cfg_cdc_sync_o;
   logic              cdc_sync_done_i = 1'b0;
   logic              timeout_o;
   logic              spurious_o;
   logic              clr_err_i = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [31:0] launch_q[$];
   logic [35:0] exp_q[$];

   pwrmgr_cdc_sync_ctrl #(
      .NumReq(NumReq),
      .TimeoutCycles(TimeoutCycles)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .req_i(req_i),
      .ack_o(ack_o),
      .ack_err_o(ack_err_o),
      .busy_o(busy_o),
      .cfg_cdc_sync_o(cfg_cdc_sync_o),
      .cdc_sync_done_i(cdc_sync_done_i),
      .timeout_o(timeout_o),
      .spurious_o(spurious_o),
      .clr_err_i(clr_err_i)
   );

   // clock / cycle counter
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic goto_cycle(input int c);
      while (cyc < c) step();
   endtask

   task automatic push_ack(input int c, input logic err, input logic [2:0] a);
      exp_q.push_back({32'(c), err, a});
   endtask

   task automatic pulse_req(input logic [2:0] v);
      req_i = v;
      step();
      req_i = '0;
   endtask

   task automatic pulse_done();
      cdc_sync_done_i = 1'b1;
      step();
      cdc_sync_done_i = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk_i) begin
      if (cfg_cdc_sync_o) begin
         if (launch_q.size() == 0) check("launch_unexpected", 64'(cyc), 64'(0));
         else check("launch_cycle", 64'(cyc), 64'(launch_q.pop_front()));
      end
      if (ack_o != '0 || ack_err_o) begin
         if (exp_q.size() == 0) check("ack_unexpected", 64'({ack_err_o, ack_o}), 64'(0));
         else check("ack", 64'({32'(cyc), ack_err_o, ack_o}), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      int t;
      int l;
      // reset state
      step();
      step();
      check("rst_ack", 64'(ack_o), 64'(0));
      check("rst_busy", 64'(busy_o), 64'(0));
      check("rst_sync", 64'(cfg_cdc_sync_o), 64'(0));
      check("rst_flags", 64'({ack_err_o, timeout_o, spurious_o}), 64'(0));
      rst_i = 1'b0;
      step();
      step();

      // single request: launch next cycle, ack the cycle after done
      t = cyc;
      launch_q.push_back(32'(t + 1));
      pulse_req(3'b001);
      check("single_busy_launch", 64'(busy_o), 64'(1));
      goto_cycle(t + 6);
      push_ack(t + 7, 1'b0, 3'b001);
      pulse_done();
      check("single_busy_after", 64'(busy_o), 64'(0));
      goto_cycle(t + 10);

      // batching: requests during WAIT form the next batch, launched with the ack
      t = cyc;
      launch_q.push_back(32'(t + 1));
      pulse_req(3'b001);
      goto_cycle(t + 3);
      pulse_req(3'b010);
      goto_cycle(t + 5);
      pulse_req(3'b100);
      goto_cycle(t + 7);
      push_ack(t + 8, 1'b0, 3'b001);
      launch_q.push_back(32'(t + 8));
      pulse_done();
      check("batch_busy_relaunch", 64'(busy_o), 64'(1));
      goto_cycle(t + 12);
      push_ack(t + 13, 1'b0, 3'b110);
      pulse_done();
      check("batch_busy_end", 64'(busy_o), 64'(0));
      goto_cycle(t + 16);

      // simultaneous requests, plus a request coinciding with done
      t = cyc;
      launch_q.push_back(32'(t + 1));
      pulse_req(3'b111);
      goto_cycle(t + 4);
      push_ack(t + 5, 1'b0, 3'b111);
      launch_q.push_back(32'(t + 5));
      req_i = 3'b010;
      pulse_done();
      req_i = '0;
      goto_cycle(t + 7);
      push_ack(t + 8, 1'b0, 3'b010);
      pulse_done();
      goto_cycle(t + 11);

      // timeout, late done flagged spurious, clear, set-wins-over-clear
      t = cyc;
      l = t + 1;
      launch_q.push_back(32'(l));
      push_ack(l + TimeoutCycles, 1'b1, 3'b010);
      pulse_req(3'b010);
      goto_cycle(l + 7);
      check("to_flag_before", 64'(timeout_o), 64'(0));
      step();
      check("to_flag_set", 64'(timeout_o), 64'(1));
      goto_cycle(l + 10);
      check("to_flag_sticky", 64'(timeout_o), 64'(1));
      pulse_done();
      check("spurious_set", 64'(spurious_o), 64'(1));
      step();
      clr_err_i = 1'b1;
      step();
      clr_err_i = 1'b0;
      check("clr_flags", 64'({timeout_o, spurious_o}), 64'(0));
      step();
      clr_err_i = 1'b1;
      pulse_done();
      clr_err_i = 1'b0;
      check("set_wins_clr", 64'({timeout_o, spurious_o}), 64'(1));
      clr_err_i = 1'b1;
      step();
      clr_err_i = 1'b0;
      check("clr_again", 64'(spurious_o), 64'(0));
      step();

      // done exactly at the timeout threshold: done wins, no error
      t = cyc;
      l = t + 1;
      launch_q.push_back(32'(l));
      pulse_req(3'b100);
      goto_cycle(l + TimeoutCycles - 1);
      push_ack(l + TimeoutCycles, 1'b0, 3'b100);
      pulse_done();
      step();
      check("tie_no_timeout", 64'(timeout_o), 64'(0));
      step();

      // reset mid-operation with a pending request: nothing is ever acked
      t = cyc;
      launch_q.push_back(32'(t + 1));
      pulse_req(3'b001);
      goto_cycle(t + 3);
      pulse_req(3'b010);
      rst_i = 1'b1;
      #1;
      check("midrst_busy", 64'(busy_o), 64'(0));
      check("midrst_outs", 64'({ack_o, ack_err_o, cfg_cdc_sync_o, timeout_o, spurious_o}), 64'(0));
      step();
      step();
      rst_i = 1'b0;
      goto_cycle(t + 18);
      check("midrst_idle", 64'(busy_o), 64'(0));
      t = cyc;
      launch_q.push_back(32'(t + 1));
      pulse_req(3'b100);
      goto_cycle(t + 3);
      push_ack(t + 4, 1'b0, 3'b100);
      pulse_done();
      step();
      step();

      check("launch_q_left", 64'(launch_q.size()), 64'(0));
      check("exp_q_left", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
